// File: rtl/vga_timing_gen_pkg.sv
// Default 640x480@60 raster constants and the helper that sums an axis into its total length.
package vga_timing_pkg;

  function automatic int unsigned axis_total(input int unsigned visible,
                                             input int unsigned fp,
                                             input int unsigned sync,
                                             input int unsigned bp);
    return visible + fp + sync + bp;
  endfunction

  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FP      = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BP      = 48;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FP      = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BP      = 29;
  localparam int unsigned DEF_CLK_DIV   = 4;

  localparam int unsigned DEF_H_TOTAL =
    axis_total(DEF_H_VISIBLE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int unsigned DEF_V_TOTAL =
    axis_total(DEF_V_VISIBLE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_timing_gen_if.sv
// Timing-generator output bundle plus run enable; master is the generator, slave the pixel pipeline.
interface vga_timing_gen_if #(
  parameter int unsigned CNT_W   = 10,
  parameter int unsigned FRAME_W = 8
);
  logic               en;
  logic               pixel_en;
  logic [CNT_W-1:0]   pixel_x;
  logic [CNT_W-1:0]   pixel_y;
  logic               h_sync;
  logic               v_sync;
  logic               blank;
  logic               last_column;
  logic               last_row;
  logic               line_start;
  logic               frame_start;
  logic [FRAME_W-1:0] frame_count;

  modport master (
    input  en,
    output pixel_en, pixel_x, pixel_y, h_sync, v_sync, blank,
           last_column, last_row, line_start, frame_start, frame_count
  );

  modport slave (
    output en,
    input  pixel_en, pixel_x, pixel_y, h_sync, v_sync, blank,
           last_column, last_row, line_start, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen_axis_counter.sv
// One raster axis: wrapping position counter with sync, blank and last-visible decode.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned VISIBLE  = DEF_H_VISIBLE,
  parameter int unsigned FP       = DEF_H_FP,
  parameter int unsigned SYNC     = DEF_H_SYNC,
  parameter int unsigned BP       = DEF_H_BP,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned CNT_W    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap,
  output logic             sync,
  output logic             blank_axis,
  output logic             last_visible
);
  localparam int unsigned      TOTAL      = axis_total(VISIBLE, FP, SYNC, BP);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] SYNC_FIRST = CNT_W'(VISIBLE + FP);
  localparam logic [CNT_W-1:0] SYNC_LAST  = CNT_W'(VISIBLE + FP + SYNC - 1);
  localparam logic [CNT_W-1:0] VIS_LAST   = CNT_W'(VISIBLE - 1);
  localparam logic [CNT_W-1:0] VIS_END    = CNT_W'(VISIBLE);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync_active;

  assign wrap = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (step) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sync_active  = (cnt_q >= SYNC_FIRST) && (cnt_q <= SYNC_LAST);
  assign sync         = SYNC_POL ? sync_active : ~sync_active;
  assign blank_axis   = (cnt_q >= VIS_END);
  assign last_visible = (cnt_q == VIS_LAST);
  assign cnt          = cnt_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel-rate divider driving horizontal and vertical axes.
// Define VGA_TIMING_FRAME_CNT_EN to build the completed-frame counter; otherwise frame_count is 0.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE  = DEF_H_VISIBLE,
  parameter int unsigned H_FP       = DEF_H_FP,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BP       = DEF_H_BP,
  parameter int unsigned V_VISIBLE  = DEF_V_VISIBLE,
  parameter int unsigned V_FP       = DEF_V_FP,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BP       = DEF_V_BP,
  parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0,
  parameter int unsigned CNT_W      = 10,
  parameter int unsigned FRAME_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  vga_timing_gen_if.master vga
);
  localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             pixel_en;
  logic [CNT_W-1:0] x_cnt, y_cnt;
  logic             h_wrap, v_wrap, v_step;
  logic             h_sync, v_sync;
  logic             h_blank, v_blank;
  logic             h_last, v_last;
  logic             line_start;

  // Divider holds its phase while en is low so a resumed run finishes the interrupted pixel.
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (vga.en) begin
      div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  assign pixel_en = vga.en & (div_cnt_q == DIV_LAST);
  assign v_step   = h_wrap & pixel_en;

  vga_axis_counter #(
    .VISIBLE  (H_VISIBLE),
    .FP       (H_FP),
    .SYNC     (H_SYNC),
    .BP       (H_BP),
    .SYNC_POL (H_SYNC_POL),
    .CNT_W    (CNT_W)
  ) u_h_axis (
    .clk          (clk),
    .rst          (rst),
    .step         (pixel_en),
    .cnt          (x_cnt),
    .wrap         (h_wrap),
    .sync         (h_sync),
    .blank_axis   (h_blank),
    .last_visible (h_last)
  );

  vga_axis_counter #(
    .VISIBLE  (V_VISIBLE),
    .FP       (V_FP),
    .SYNC     (V_SYNC),
    .BP       (V_BP),
    .SYNC_POL (V_SYNC_POL),
    .CNT_W    (CNT_W)
  ) u_v_axis (
    .clk          (clk),
    .rst          (rst),
    .step         (v_step),
    .cnt          (y_cnt),
    .wrap         (v_wrap),
    .sync         (v_sync),
    .blank_axis   (v_blank),
    .last_visible (v_last)
  );

  assign line_start = pixel_en & (x_cnt == '0);

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [FRAME_W-1:0] frame_q, frame_d;

  always_comb begin
    frame_d = frame_q;
    if (v_wrap & v_step) begin
      frame_d = frame_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q <= '0;
    end else begin
      frame_q <= frame_d;
    end
  end

  assign vga.frame_count = frame_q;
`else
  logic unused_v_wrap;
  assign unused_v_wrap   = v_wrap;
  assign vga.frame_count = '0;
`endif

  assign vga.pixel_en    = pixel_en;
  assign vga.pixel_x     = x_cnt;
  assign vga.pixel_y     = y_cnt;
  assign vga.h_sync      = h_sync;
  assign vga.v_sync      = v_sync;
  assign vga.blank       = h_blank | v_blank;
  assign vga.last_column = h_last;
  assign vga.last_row    = v_last;
  assign vga.line_start  = line_start;
  assign vga.frame_start = line_start & (y_cnt == '0);

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA/raster timing generator; successor to the fixed 640x480 timing block. Divides the system clock to a pixel rate, runs horizontal and vertical position counters, and decodes sync, blank, edge flags and line/frame start strobes for the pixel pipeline and display output. Adds a configurable video mode, programmable sync polarity, a run-enable input and an optional frame counter.

## Interface
Parameters:
- `H_VISIBLE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch (pixels)
- `H_SYNC`, 96: horizontal sync width (pixels)
- `H_BP`, 48: horizontal back porch (pixels)
- `V_VISIBLE`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch (lines)
- `V_SYNC`, 2: vertical sync width (lines)
- `V_BP`, 29: vertical back porch (lines)
- `CLK_DIV`, 4: system clocks per pixel, ≥1
- `H_SYNC_POL`, 0: active level of `h_sync` (0 = active low)
- `V_SYNC_POL`, 0: active level of `v_sync`
- `CNT_W`, 10: width of `pixel_x`/`pixel_y`; must hold H_TOTAL-1 and V_TOTAL-1
- `FRAME_W`, 8: width of `frame_count`

Ports:
- `clk` in 1: system clock
- `rst` in 1: synchronous reset, active-high
- `en` in 1: run enable; low freezes all timing
- `pixel_en` out 1: one-clock strobe; counters advance on this edge
- `pixel_x` out CNT_W: horizontal position
- `pixel_y` out CNT_W: vertical position
- `h_sync` out 1: horizontal sync, level per H_SYNC_POL
- `v_sync` out 1: vertical sync, level per V_SYNC_POL
- `blank` out 1: high outside the visible area
- `last_column` out 1: `pixel_x == H_VISIBLE-1`
- `last_row` out 1: `pixel_y == V_VISIBLE-1`, any column
- `line_start` out 1: `pixel_en & pixel_x==0`
- `frame_start` out 1: `line_start & pixel_y==0`
- `frame_count` out FRAME_W: completed frames, mod 2^FRAME_W

## Operation
- Derived constants: H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL likewise (default 521).
- Divider `div_cnt` counts 0..CLK_DIV-1 while `en`=1; it holds while `en`=0. `pixel_en` = `en & div_cnt==CLK_DIV-1`. With CLK_DIV=1, `pixel_en` = `en`.
- On `pixel_en`: `pixel_x` increments. At H_TOTAL-1 it wraps to 0 and `pixel_y` increments. At (V_TOTAL-1, H_TOTAL-1) both counters wrap to 0 and `frame_count` increments.
- Sync is active for `pixel_x` in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1] (default 656..751). Vertical sync uses the same rule on `pixel_y` (default 490..491). Otherwise sync is at its inactive level.
- `blank` = `pixel_x >= H_VISIBLE | pixel_y >= V_VISIBLE`.
- All outputs except `frame_count` decode combinationally from registered counters. They stay aligned with `pixel_x`/`pixel_y` and have zero latency relative to them.
- Reset: `div_cnt`, `pixel_x`, `pixel_y` and `frame_count` go to 0. Resulting outputs: `pixel_en`=0, `h_sync`=!H_SYNC_POL, `v_sync`=!V_SYNC_POL, `blank`=0, `last_column`=0, `last_row`=0, `line_start`=0, `frame_start`=0.
- Reset mid-frame takes effect on the next edge. The first advance after release comes CLK_DIV clocks later, to (0,1).
- `rst` overrides `en`. `en` falling on a `pixel_en` cycle suppresses that advance.

## Timing
- Counters update on the `clk` edge where `pixel_en`=1. They are stable for CLK_DIV clocks when `en` is held high.
- `frame_start` fires on the first `pixel_en` after reset, CLK_DIV clocks after release. It then fires once per H_TOTAL·V_TOTAL·CLK_DIV clocks (default 1,667,200).
- `frame_count` updates on the same edge as the (0,0) wrap.

## Configuration
- `VGA_TIMING_FRAME_CNT_EN` defined: the `frame_count` register and incrementer are built as described.
- `VGA_TIMING_FRAME_CNT_EN` undefined: `frame_count` is tied to 0 and no register is inferred. All other behaviour is unchanged.

## Structure
- Package `vga_timing_pkg` holds the default 640x480@60 constants (visible, porch and sync widths, totals, default CLK_DIV) and the function computing H_TOTAL/V_TOTAL.
- Sub-module `vga_axis_counter` is instantiated twice, once for horizontal and once for vertical.
  - Parameters: VISIBLE, FP, SYNC, BP, SYNC_POL, CNT_W.
  - Inputs: `clk`, `rst`, `step`.
  - Outputs: `cnt`, `wrap`, `sync`, `blank_axis`, `last_visible`.
  - The vertical instance's `step` = horizontal `wrap & pixel_en`.

## Test plan
- Defaults, run from reset → at (0,0): `h_sync`=1, `v_sync`=1, `blank`=0, `frame_start` pulses. At (0,639): `last_column`=1. At (0,640): `blank`=1.
- Defaults, horizontal sync → `h_sync`=0 at x=656 and x=751; `h_sync`=1 at x=752. Vertical sync → `v_sync`=0 at y=490 and y=491; `v_sync`=1 at y=492. At (479,639): `last_row`=1, `blank`=0.
- Wrap checks → (10,799) advances to (11,0). (520,799) advances to (0,0) and `frame_count` goes 0→1 (0 when the macro is undefined).
- Mid-run reset: `rst` high for 1 clock at (100,100) → (0,0) on the next edge. After 4 clocks with no `pixel_en` before the 4th, position is (0,1).
- `en` held low for 20 clocks at (5,200) → counters and `div_cnt` frozen, `pixel_en`=0. After release, advance to (5,201) after the remaining divider count.
- Small mode: H 8/2/2/2, V 4/1/1/1, CLK_DIV=1, H_SYNC_POL=1 → `pixel_en` constant high, `h_sync`=1 at x=10..11, frame period 14·7=98 clocks, `frame_count`=3 after 294 clocks.
